// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 WIDTH-bit mux among eight requesters, feeding a
// single-entry valid/ready output buffer. Define MUX_RR_ARBITER_STATS_EN to add xfer_count.
module mux_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         gnt,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_src,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]        xfer_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_reg;
  logic [2:0]         ptr_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [2:0]         out_src_reg;

  logic [WIDTH-1:0]   words [8];
  logic [7:0]         rot_req;
  logic [2:0]         offset;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   mux_out;
  logic               any_req;
  logic               load;
  logic               grant_en;

  // rot_req[k] is the request of the source k positions after ptr, so the
  // lowest set bit of rot_req is the round-robin winner.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lanes
      assign words[gi]   = in_data[gi*WIDTH +: WIDTH];
      assign rot_req[gi] = req[3'(ptr_reg + 3'(gi))];
      assign gnt[gi]     = grant_en && (sel == 3'(gi));
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) offset = 3'(k);
    end
  end

  assign sel      = ptr_reg + offset;
  assign mux_out  = words[sel];
  assign any_req  = |req;
  assign load     = (state_reg == EMPTY) || out_ready;
  assign grant_en = !reset && load && any_req;

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= EMPTY;
      ptr_reg      <= 3'd0;
      out_data_reg <= '0;
      out_src_reg  <= 3'd0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (grant_en) begin
            state_reg    <= FULL;
            out_data_reg <= mux_out;
            out_src_reg  <= sel;
            ptr_reg      <= sel + 3'd1;
          end
        end
        FULL: begin
          // A grant here implies out_ready, so drain and refill happen together.
          if (grant_en) begin
            out_data_reg <= mux_out;
            out_src_reg  <= sel;
            ptr_reg      <= sel + 3'd1;
          end else if (out_ready) begin
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  logic [15:0] xfer_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_reg <= 16'd0;
    end else if (out_valid && out_ready) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed cycles push expected words,
// a negedge monitor pops and compares each word as it is consumed.
module tb_mux_rr_arbiter;

  localparam int WIDTH = 32;

  logic               clk;
  logic               reset;
  logic [7:0]         req;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         gnt;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_src;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [15:0]        xfer_count;
`endif

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: a word is consumed at the next edge when out_valid & out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected: got data=%0h src=%0d expected no word", out_data, out_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_src !== e.src) begin
          errors++;
          $display("FAIL monitor_word: got data=%0h src=%0d expected data=%0h src=%0d",
                   out_data, out_src, e.data, e.src);
        end else begin
          $display("xfer: data=%0h src=%0d", out_data, out_src);
        end
      end
    end
  end

  // One cycle: drive at posedge+2, check gnt at posedge+8 and record the expected word.
  task automatic cyc(input logic [7:0] r, input logic rdy, input logic [7:0] exp_gnt);
    @(posedge clk);
    #2;
    req       = r;
    out_ready = rdy;
    #6;
    check("gnt", {24'd0, gnt}, {24'd0, exp_gnt});
    for (int i = 0; i < 8; i++) begin
      if (exp_gnt[i]) exp_q.push_back('{data: 32'(1) << i, src: 3'(i)});
    end
    $display("cycle: req=%02h ready=%0b gnt=%02h valid=%0b data=%0h src=%0d",
             r, rdy, gnt, out_valid, out_data, out_src);
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req       = r;
    out_ready = 1'b0;
    #6;
    check("gnt_in_reset", {24'd0, gnt}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    req   = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 32'(1) << i;
    reset     = 1'b1;
    req       = 8'h00;
    out_ready = 1'b1;
    do_reset(8'hFF);

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 1'b1, 8'h00);
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_data", out_data, 32'd0);
      check("idle_src", {29'd0, out_src}, 32'd0);
    end

    // Single requester 3.
    cyc(8'h08, 1'b1, 8'h08);
    cyc(8'h00, 1'b1, 8'h00);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", out_data, 32'd8);
    cyc(8'h00, 1'b1, 8'h00);
    check("single_drained", {31'd0, out_valid}, 32'd0);

    // Round robin from ptr 0: grants 0..7 then 0.
    do_reset(8'h00);
    for (int k = 0; k < 9; k++) cyc(8'hFF, 1'b1, 8'(1) << (k % 8));
    cyc(8'h00, 1'b1, 8'h00);

    // ptr=1: grant 5 moves ptr to 6, then 6, 0, 6.
    cyc(8'h20, 1'b1, 8'h20);
    cyc(8'h41, 1'b1, 8'h40);
    cyc(8'h41, 1'b1, 8'h01);
    cyc(8'h41, 1'b1, 8'h40);
    cyc(8'h00, 1'b1, 8'h00);

    // Backpressure: ptr=7, req 0 and 4.
    cyc(8'h11, 1'b1, 8'h01);
    for (int k = 0; k < 4; k++) begin
      cyc(8'h11, 1'b0, 8'h00);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'd1);
      check("bp_src", {29'd0, out_src}, 32'd0);
    end
    cyc(8'h11, 1'b1, 8'h10);
    cyc(8'h00, 1'b1, 8'h00);
    check("bp_next_data", out_data, 32'd16);
    cyc(8'h00, 1'b1, 8'h00);

    // Reset mid-transfer with source 5 buffered (ptr=5).
    cyc(8'h20, 1'b1, 8'h20);
    cyc(8'h00, 1'b0, 8'h00);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_src", {29'd0, out_src}, 32'd5);
    do_reset(8'hFF);
    cyc(8'hFF, 1'b1, 8'h01);
`ifdef MUX_RR_ARBITER_STATS_EN
    check("stats_after_reset", {16'd0, xfer_count}, 32'd0);
`endif
    cyc(8'h00, 1'b1, 8'h00);
    cyc(8'h00, 1'b1, 8'h00);
    check("final_valid", {31'd0, out_valid}, 32'd0);
`ifdef MUX_RR_ARBITER_STATS_EN
    check("stats_one_xfer", {16'd0, xfer_count}, 32'd1);
`endif
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
